// File: rtl/hilo_seq_if.sv
// HI/LO sequencer bus: host request/write port, multiplier and divider
// operand/result links, and the architectural HI/LO view with status.
`timescale 1ns/1ps
interface hilo_seq_if;
    // Host request and direct-write side
    logic        op_start;
    logic [1:0]  op_sel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;

    // Multiplier link
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_sign;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;

    // Divider link
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_sign;
    logic [31:0] div_r;
    logic [31:0] div_q;

    // Architectural state and status
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    // The sequencer itself
    modport slave (
        input  op_start, op_sel, rs_val, rt_val, mthi, mtlo, wdata,
        input  mul_hi, mul_lo, div_r, div_q,
        output mul_a, mul_b, mul_sign, div_a, div_b, div_sign,
        output hi, lo, busy, done
    );

    // The pipeline plus arithmetic units surrounding the sequencer
    modport master (
        output op_start, op_sel, rs_val, rt_val, mthi, mtlo, wdata,
        output mul_hi, mul_lo, div_r, div_q,
        input  mul_a, mul_b, mul_sign, div_a, div_b, div_sign,
        input  hi, lo, busy, done
    );
endinterface

// File: rtl/hilo_seq.sv
// HI/LO sequencer: launches a multi-cycle multiply or divide on external
// arithmetic units, stalls the pipeline while the unit works, then captures
// the unit's result into the architectural HI/LO registers.
`timescale 1ns/1ps
module hilo_seq #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    hilo_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter is preloaded with N-1 so that the result lands exactly N
    // edges after the launch edge.
    localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    state_t      r_state;
    state_t      w_stateNext;
    logic [7:0]  r_count;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [1:0]  r_opSel;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_launch;
    logic        w_writeResult;
    logic        w_hostWrite;

    // Next-state and action decode; host writes only land while idle
    always_comb begin
        w_stateNext   = r_state;
        w_launch      = 1'b0;
        w_writeResult = 1'b0;
        w_hostWrite   = 1'b0;
        case (r_state)
            IDLE: begin
                w_hostWrite = 1'b1;
                if (bus.op_start) begin
                    w_launch    = 1'b1;
                    w_stateNext = BUSY;
                end
            end
            BUSY: begin
                if (r_count == 8'd0) begin
                    w_writeResult = 1'b1;
                    w_stateNext   = DONE;
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Busy-cycle counter: loaded on launch, counts down to zero while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (w_launch) begin
            r_count <= bus.op_sel[1] ? DIV_LOAD : MUL_LOAD;
        end else if ((r_state == BUSY) && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    // Operand and operation latch, so the units see stable inputs for the
    // whole operation regardless of what the pipeline does meanwhile
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opA   <= 32'd0;
            r_opB   <= 32'd0;
            r_opSel <= 2'b00;
        end else if (w_launch) begin
            r_opA   <= bus.rs_val;
            r_opB   <= bus.rt_val;
            r_opSel <= bus.op_sel;
        end
    end

    // HI/LO update: unit result on completion, otherwise direct host writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_writeResult) begin
            if (r_opSel[1]) begin
                r_hi <= bus.div_r;
                r_lo <= bus.div_q;
            end else begin
                r_hi <= bus.mul_hi;
                r_lo <= bus.mul_lo;
            end
        end else if (w_hostWrite) begin
            if (bus.mthi) begin
                r_hi <= bus.wdata;
            end
            if (bus.mtlo) begin
                r_lo <= bus.wdata;
            end
        end
    end

    // Both units share the latched operands; op_sel[0] set means unsigned
    assign bus.mul_a    = r_opA;
    assign bus.mul_b    = r_opB;
    assign bus.mul_sign = ~r_opSel[0];
    assign bus.div_a    = r_opA;
    assign bus.div_b    = r_opB;
    assign bus.div_sign = ~r_opSel[0];

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = (r_state == BUSY);
    assign bus.done = (r_state == DONE);

endmodule

// File: tb/tb_hilo_seq.sv
// Bench for hilo_seq: models the external multiplier/divider, drives directed
// and random operations, and checks results through a scoreboard queue.
`timescale 1ns/1ps
module tb_hilo_seq;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic clk = 1'b0;
    logic rst;

    hilo_seq_if bus();

    hilo_seq #(
        .MUL_CYCLES(MUL_N),
        .DIV_CYCLES(DIV_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz clock
    initial begin
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] refHi  = 32'd0;
    logic [31:0] refLo  = 32'd0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // External multiplier: explicit sign/zero extension to 64 bits
    function automatic logic [63:0] unitMul(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    // External divider: returns {remainder, quotient}; zero divisor gives zeros
    function automatic logic [63:0] unitDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa;
        longint sb;
        if (b == 32'd0) return 64'd0;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    assign {bus.mul_hi, bus.mul_lo} = unitMul(bus.mul_a, bus.mul_b, bus.mul_sign);
    assign {bus.div_r, bus.div_q}   = unitDiv(bus.div_a, bus.div_b, bus.div_sign);

    // Architectural meaning of each operation, as {HI, LO}
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        case (op)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return 64'(p);
            end
            2'b01: begin
                p = longint'(a) * longint'(b);
                return 64'(p);
            end
            2'b10: begin
                if (b == 32'd0) return 64'd0;
                return {32'(longint'($signed(a)) % longint'($signed(b))),
                        32'(longint'($signed(a)) / longint'($signed(b)))};
            end
            default: begin
                if (b == 32'd0) return 64'd0;
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation
    initial begin
        int   busyCount;
        bit   prevDone;
        exp_t e;
        busyCount = 0;
        prevDone  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busyCount = 0;
                prevDone  = 1'b0;
            end else begin
                if (prevDone) checkOutput("done single-cycle", 64'(bus.done), 64'd0);
                prevDone = bus.done;
                if (bus.busy) busyCount++;
                if (bus.done) begin
                    checkOutput("done has pending expectation", 64'(expQ.size() > 0), 64'd1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        checkOutput("result hi", 64'(bus.hi), 64'(e.hi));
                        checkOutput("result lo", 64'(bus.lo), 64'(e.lo));
                        checkOutput("busy cycle count", 64'(busyCount), 64'(e.cycles));
                    end
                    busyCount = 0;
                end
            end
        end
    end

    task automatic hostWrite(input bit wHi, input bit wLo, input logic [31:0] d);
        @(posedge clk); #2;
        bus.mthi  = wHi;
        bus.mtlo  = wLo;
        bus.wdata = d;
        @(posedge clk); #2;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        if (wHi) refHi = d;
        if (wLo) refLo = d;
        checkOutput("host write hi", 64'(bus.hi), 64'(refHi));
        checkOutput("host write lo", 64'(bus.lo), 64'(refLo));
        checkOutput("host write busy", 64'(bus.busy), 64'd0);
    endtask

    // Launch one operation, optionally with a same-cycle mthi and with
    // ignored disturbances while busy, then wait (bounded) for completion.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expHi, input logic [31:0] expLo,
                                 input bit disturb, input bit withMthi, input logic [31:0] wd);
        exp_t e;
        int   n;
        bit   seen;
        n = op[1] ? DIV_N : MUL_N;
        @(posedge clk); #2;
        bus.op_start = 1'b1;
        bus.op_sel   = op;
        bus.rs_val   = a;
        bus.rt_val   = b;
        bus.mthi     = withMthi;
        bus.wdata    = wd;
        e.hi = expHi;
        e.lo = expLo;
        e.cycles = n;
        expQ.push_back(e);
        @(posedge clk); #2;
        bus.op_start = 1'b0;
        bus.mthi     = 1'b0;
        if (withMthi) begin
            refHi = wd;
            checkOutput("mthi with launch", 64'(bus.hi), 64'(wd));
        end
        checkOutput("busy after launch", 64'(bus.busy), 64'd1);
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        bus.op_sel = 2'($urandom_range(0, 3));
        if (disturb) begin
            bus.op_start = 1'b1;
            bus.mthi     = 1'b1;
            bus.mtlo     = 1'b1;
            bus.wdata    = $urandom;
            @(posedge clk); #2;
            bus.op_start = 1'b0;
            bus.mthi     = 1'b0;
            bus.mtlo     = 1'b0;
            checkOutput("mthi ignored while busy", 64'(bus.hi), 64'(refHi));
            checkOutput("mtlo ignored while busy", 64'(bus.lo), 64'(refLo));
        end
        seen = 1'b0;
        for (int i = 0; i < n + 4; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        checkOutput("done within budget", 64'(seen), 64'd1);
        refHi = expHi;
        refLo = expLo;
        if (seen) begin
            bus.op_start = 1'b1;
            bus.op_sel   = op;
            @(posedge clk); #2;
            bus.op_start = 1'b0;
            checkOutput("op_start ignored in done", 64'(bus.busy), 64'd0);
        end
    endtask

    task automatic resetMidDivide();
        @(posedge clk); #2;
        bus.op_start = 1'b1;
        bus.op_sel   = 2'b10;
        bus.rs_val   = 32'hFFFF_FFF9;
        bus.rt_val   = 32'd2;
        @(posedge clk); #2;
        bus.op_start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        checkOutput("busy before reset", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("reset hi", 64'(bus.hi), 64'd0);
        checkOutput("reset lo", 64'(bus.lo), 64'd0);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset done", 64'(bus.done), 64'd0);
        checkOutput("reset operand a", 64'(bus.mul_a), 64'd0);
        checkOutput("reset operand b", 64'(bus.div_b), 64'd0);
        checkOutput("reset sign", 64'(bus.div_sign), 64'd1);
        @(posedge clk); #2;
        rst   = 1'b0;
        refHi = 32'd0;
        refLo = 32'd0;
        repeat (40) @(posedge clk);
        #2;
        checkOutput("no write after reset hi", 64'(bus.hi), 64'd0);
        checkOutput("no write after reset lo", 64'(bus.lo), 64'd0);
        checkOutput("idle after reset", 64'(bus.busy), 64'd0);
    endtask

    // Global time limit
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main stimulus sequence
    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] r;
        rst          = 1'b1;
        bus.op_start = 1'b0;
        bus.op_sel   = 2'b00;
        bus.rs_val   = 32'd0;
        bus.rt_val   = 32'd0;
        bus.mthi     = 1'b0;
        bus.mtlo     = 1'b0;
        bus.wdata    = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("initial hi", 64'(bus.hi), 64'd0);
        checkOutput("initial lo", 64'(bus.lo), 64'd0);
        checkOutput("initial busy", 64'(bus.busy), 64'd0);
        checkOutput("initial done", 64'(bus.done), 64'd0);
        rst = 1'b0;

        hostWrite(1'b1, 1'b0, 32'hA5A5_A5A5);
        hostWrite(1'b0, 1'b1, 32'h1234_5678);
        hostWrite(1'b1, 1'b1, 32'hCAFE_F00D);

        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0);
        applyStimulus(2'b11, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        applyStimulus(2'b00, 32'h0000_1234, 32'h0000_0010, 32'd0, 32'h0001_2340, 1'b1, 1'b0, 32'd0);
        applyStimulus(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 1'b1, 32'h5555_AAAA);

        hostWrite(1'b1, 1'b1, 32'h0BAD_BEEF);
        resetMidDivide();

        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            r  = refModel(op, a, b);
            applyStimulus(op, a, b, r[63:32], r[31:0], (i % 4) == 1, (i % 5) == 2, 32'($urandom));
        end

        repeat (4) @(posedge clk);
        #2;
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
